// File: rtl/prg_monitor_ctrl.sv
// rtl/prg_monitor_ctrl.sv - monitor byte-command sequencer for the CDEC memory program port
module prg_monitor_ctrl (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       prg_we,
    output logic [7:0] prg_MA,
    output logic [7:0] prg_WD,
    input  logic [7:0] prg_RD,
    output logic       busy
);

    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_D = 8'h44;
    localparam logic [7:0] CMD_F = 8'h46;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_GET_ADDR  = 4'd1;
    localparam logic [3:0] S_GET_CNT   = 4'd2;
    localparam logic [3:0] S_GET_DATA  = 4'd3;
    localparam logic [3:0] S_WRITE     = 4'd4;
    localparam logic [3:0] S_RD_ADDR   = 4'd5;
    localparam logic [3:0] S_RD_WAIT   = 4'd6;
    localparam logic [3:0] S_SEND      = 4'd7;
    localparam logic [3:0] S_SEND_STAT = 4'd8;

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [7:0] cmd;
    logic [8:0] remaining;
    logic       rx_acc;
    logic       tx_acc;
    logic       cmd_known;

    assign rx_acc    = rx_valid && rx_ready;
    assign tx_acc    = tx_valid && tx_ready;
    assign cmd_known = (rx_data == CMD_W) || (rx_data == CMD_R) ||
                       (rx_data == CMD_D) || (rx_data == CMD_F);
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (rx_acc) state_nxt = cmd_known ? S_GET_ADDR : S_SEND_STAT;
            S_GET_ADDR: begin
                if (rx_acc) begin
                    if (cmd == CMD_W)      state_nxt = S_GET_DATA;
                    else if (cmd == CMD_R) state_nxt = S_RD_ADDR;
                    else                   state_nxt = S_GET_CNT;
                end
            end
            S_GET_CNT:   if (rx_acc) state_nxt = (cmd == CMD_D) ? S_RD_ADDR : S_GET_DATA;
            S_GET_DATA:  if (rx_acc) state_nxt = S_WRITE;
            S_WRITE:     if (remaining == 9'd1) state_nxt = S_SEND_STAT;
            S_RD_ADDR:   state_nxt = S_RD_WAIT;
            S_RD_WAIT:   state_nxt = S_SEND;
            S_SEND:      if (tx_acc) state_nxt = (remaining != 9'd0) ? S_RD_ADDR : S_IDLE;
            S_SEND_STAT: if (tx_acc) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // rx_ready and prg_we are registered from the next state so both are glitch-free and low in reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cmd       <= 8'h00;
            remaining <= 9'd0;
            rx_ready  <= 1'b0;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            prg_we    <= 1'b0;
            prg_MA    <= 8'h00;
            prg_WD    <= 8'h00;
        end else begin
            state    <= state_nxt;
            rx_ready <= (state_nxt == S_IDLE) || (state_nxt == S_GET_ADDR) ||
                        (state_nxt == S_GET_CNT) || (state_nxt == S_GET_DATA);
            prg_we   <= (state_nxt == S_WRITE);
            case (state)
                S_IDLE: begin
                    if (rx_acc) begin
                        cmd <= rx_data;
                        if (!cmd_known) begin
                            tx_data  <= NAK;
                            tx_valid <= 1'b1;
                        end
                    end
                end
                S_GET_ADDR: begin
                    if (rx_acc) begin
                        prg_MA    <= rx_data;
                        remaining <= 9'd1;
                    end
                end
                // a count byte of zero means a full 256-byte sweep
                S_GET_CNT:  if (rx_acc) remaining <= {(rx_data == 8'h00), rx_data};
                S_GET_DATA: if (rx_acc) prg_WD <= rx_data;
                S_WRITE: begin
                    prg_MA    <= prg_MA + 8'd1;
                    remaining <= remaining - 9'd1;
                    if (remaining == 9'd1) begin
                        tx_data  <= ACK;
                        tx_valid <= 1'b1;
                    end
                end
                S_RD_WAIT: begin
                    tx_data   <= prg_RD;
                    tx_valid  <= 1'b1;
                    prg_MA    <= prg_MA + 8'd1;
                    remaining <= remaining - 9'd1;
                end
                S_SEND, S_SEND_STAT: if (tx_acc) tx_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prg_monitor_ctrl.sv
// tb/tb_prg_monitor_ctrl.sv - directed vector bench for prg_monitor_ctrl
module tb_prg_monitor_ctrl;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       prg_we;
    logic [7:0] prg_MA;
    logic [7:0] prg_WD;
    logic [7:0] prg_RD = 8'h00;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rx_acc_cyc = 0;

    logic [7:0] mem [256];

    typedef struct { logic [7:0] ma; logic [7:0] wd; int cyc; } wr_t;
    typedef struct { logic [7:0] data; int cyc; } tx_t;
    typedef struct {
        logic [7:0] b0, b1, b2;
        int         nb;
        logic [7:0] exp_tx;
        int         exp_we;
    } vec_t;

    wr_t wlog[$];
    tx_t txq[$];
    vec_t vt[8];

    prg_monitor_ctrl dut (
        .clock(clock), .reset_n(reset_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .prg_we(prg_we), .prg_MA(prg_MA), .prg_WD(prg_WD), .prg_RD(prg_RD),
        .busy(busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (prg_we) mem[prg_MA] = prg_WD;
        prg_RD <= mem[prg_MA];
    end

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (prg_we) wlog.push_back('{prg_MA, prg_WD, cyc});
        if (tx_valid && tx_ready) txq.push_back('{tx_data, cyc});
        if (rx_valid && rx_ready) rx_acc_cyc <= cyc;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clock);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("rx_ready_seen", rx_ready, 1);
        @(posedge clock);
        #1 rx_valid = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b);
        int n = 0;
        @(negedge clock);
        tx_ready = 1'b1;
        while (txq.size() == 0 && n < 600) begin
            @(negedge clock);
            n++;
        end
        tx_ready = 1'b0;
        chk("tx_seen", txq.size() > 0, 1);
        b = (txq.size() > 0) ? txq.pop_front().data : 8'h00;
    endtask

    initial begin
        logic [7:0] got;
        int we0, n, bad;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        vt[0] = '{8'h57, 8'h10, 8'hA5, 3, 8'h06, 1};
        vt[1] = '{8'h52, 8'h10, 8'h00, 2, 8'hA5, 0};
        vt[2] = '{8'h57, 8'h00, 8'h3C, 3, 8'h06, 1};
        vt[3] = '{8'h57, 8'hFF, 8'hC3, 3, 8'h06, 1};
        vt[4] = '{8'h52, 8'h00, 8'h00, 2, 8'h3C, 0};
        vt[5] = '{8'h52, 8'hFF, 8'h00, 2, 8'hC3, 0};
        vt[6] = '{8'h41, 8'h00, 8'h00, 1, 8'h15, 0};
        vt[7] = '{8'h00, 8'h00, 8'h00, 1, 8'h15, 0};

        // reset values
        repeat (2) @(negedge clock);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_prg_we", prg_we, 0);
        chk("rst_prg_MA", prg_MA, 0);
        chk("rst_prg_WD", prg_WD, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        #1 chk("rx_ready_before_clk", rx_ready, 0);
        @(negedge clock);
        chk("rx_ready_after_clk", rx_ready, 1);
        chk("busy_idle", busy, 0);

        // table-driven single transactions
        for (int i = 0; i < 8; i++) begin
            we0 = wlog.size();
            send_byte(vt[i].b0);
            if (vt[i].nb > 1) send_byte(vt[i].b1);
            if (vt[i].nb > 2) send_byte(vt[i].b2);
            recv_byte(got);
            chk($sformatf("vec%0d_tx", i), got, vt[i].exp_tx);
            chk($sformatf("vec%0d_we_count", i), wlog.size() - we0, vt[i].exp_we);
            if (vt[i].exp_we == 1 && wlog.size() > 0) begin
                chk($sformatf("vec%0d_ma", i), wlog[$].ma, vt[i].b1);
                chk($sformatf("vec%0d_wd", i), wlog[$].wd, vt[i].b2);
            end
            @(negedge clock);
            chk($sformatf("vec%0d_busy_after", i), busy, 0);
        end

        // dump with address wrap, tx_ready held high
        mem[8'hFE] = 8'h11;
        mem[8'hFF] = 8'h22;
        mem[8'h00] = 8'h33;
        txq.delete();
        @(negedge clock);
        tx_ready = 1'b1;
        send_byte(8'h44);
        send_byte(8'hFE);
        send_byte(8'h03);
        n = 0;
        while (txq.size() < 3 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("dump_count", txq.size(), 3);
        if (txq.size() == 3) begin
            chk("dump_b0", txq[0].data, 8'h11);
            chk("dump_b1", txq[1].data, 8'h22);
            chk("dump_b2", txq[2].data, 8'h33);
            chk("dump_first_latency", txq[0].cyc - rx_acc_cyc, 3);
            chk("dump_rate_1", txq[1].cyc - txq[0].cyc, 3);
            chk("dump_rate_2", txq[2].cyc - txq[1].cyc, 3);
        end
        chk("dump_busy_after", busy, 0);
        tx_ready = 1'b0;
        txq.delete();

        // unknown command under backpressure
        we0 = wlog.size();
        send_byte(8'h41);
        n = 0;
        while (!tx_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk($sformatf("bp_tx_valid_%0d", i), tx_valid, 1);
            chk($sformatf("bp_tx_data_%0d", i), tx_data, 8'h15);
            chk($sformatf("bp_rx_ready_%0d", i), rx_ready, 0);
        end
        chk("bp_no_we", wlog.size() - we0, 0);
        recv_byte(got);
        chk("bp_nak", got, 8'h15);

        // fill of 256
        wlog.delete();
        send_byte(8'h46);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h5A);
        n = 0;
        while (!tx_valid && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk("fill_we_count", wlog.size(), 256);
        bad = 0;
        if (wlog.size() == 256) begin
            for (int i = 0; i < 256; i++) begin
                if (wlog[i].ma != i[7:0] || wlog[i].wd != 8'h5A || wlog[i].cyc != wlog[0].cyc + i)
                    bad++;
            end
        end
        chk("fill_sequence_errors", bad, 0);
        recv_byte(got);
        chk("fill_ack", got, 8'h06);
        send_byte(8'h52);
        send_byte(8'h80);
        recv_byte(got);
        chk("fill_readback_80", got, 8'h5A);

        // reset during the 5th write of a 16-byte fill
        mem[8'h24] = 8'h77;
        wlog.delete();
        txq.delete();
        @(negedge clock);
        tx_ready = 1'b1;
        send_byte(8'h46);
        send_byte(8'h20);
        send_byte(8'h10);
        send_byte(8'hFF);
        n = 0;
        while (!(prg_we && prg_MA == 8'h24) && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("midfill_5th_write_seen", prg_we && prg_MA == 8'h24, 1);
        reset_n = 1'b0;
        #1;
        chk("midrst_prg_we", prg_we, 0);
        chk("midrst_prg_MA", prg_MA, 0);
        chk("midrst_prg_WD", prg_WD, 0);
        chk("midrst_tx_valid", tx_valid, 0);
        chk("midrst_tx_data", tx_data, 0);
        chk("midrst_rx_ready", rx_ready, 0);
        chk("midrst_busy", busy, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        tx_ready = 1'b0;
        chk("midrst_writes_done", wlog.size(), 4);
        chk("midrst_no_ack", txq.size(), 0);
        send_byte(8'h52);
        send_byte(8'h24);
        recv_byte(got);
        chk("midrst_read_24", got, 8'h77);
        send_byte(8'h52);
        send_byte(8'h23);
        recv_byte(got);
        chk("midrst_read_23", got, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/prg_monitor_ctrl.md
# prg_monitor_ctrl

Byte-command controller that sequences the program port (`prg_*`) of the CDEC memory on behalf of the host monitor. It takes command bytes over a valid/ready receive stream and issues single-byte writes, single-byte reads, burst dumps and fills on the RAM's second port. It returns read data and status bytes over a valid/ready transmit stream. It sits between the monitor's UART byte layer and the memory `prg_*` port. The CPU-side port is untouched.

## Interface
- `ACK`, 8'h06: status byte sent after a completed write or fill.
- `NAK`, 8'h15: status byte sent for an unknown command.
- `clock`  in  1: single clock domain, rising edge; same clock as `prg_clock`.
- `reset_n`  in  1: asynchronous, active-low reset.
- `rx_data`  in  8: incoming command/operand byte.
- `rx_valid`  in  1: `rx_data` is valid.
- `rx_ready`  out  1: controller accepts a byte when `rx_valid && rx_ready`.
- `tx_data`  out  8: response byte.
- `tx_valid`  out  1: `tx_data` is valid.
- `tx_ready`  in  1: host consumes the byte when `tx_valid && tx_ready`.
- `prg_we`  out  1: program-port write enable, one-cycle pulse per byte.
- `prg_MA`  out  8: program-port address.
- `prg_WD`  out  8: program-port write data.
- `prg_RD`  in  8: program-port read data, valid one clock after `prg_MA` is sampled.
- `busy`  out  1: high whenever state ≠ IDLE.

## Operation
- Commands, first byte of each sequence:
  - 'W' (8'h57) addr data: write one byte, then send `ACK`.
  - 'R' (8'h52) addr: read one byte and send it.
  - 'D' (8'h44) addr cnt: send `cnt` bytes starting at addr. `cnt` = 0 means 256.
  - 'F' (8'h46) addr cnt data: write `data` to `cnt` bytes (0 means 256), then send `ACK`.
  - Any other byte: send `NAK`, return to IDLE, no memory access.
- States:
  - IDLE: wait for a command byte.
  - GET_ADDR, GET_CNT, GET_DATA: collect operands.
  - WRITE: one write per cycle.
  - RD_ADDR: drive the address.
  - RD_WAIT: capture `prg_RD` into the tx register.
  - SEND: hold `tx_valid` until the handshake completes.
  - SEND_STAT: send `ACK` or `NAK`.
- Transitions:
  - IDLE goes to GET_ADDR on W/R/D/F, or to SEND_STAT on an unknown byte.
  - GET_ADDR goes to GET_DATA for W, RD_ADDR for R, and GET_CNT for D/F.
  - GET_CNT goes to RD_ADDR for D, or GET_DATA for F.
  - GET_DATA goes to WRITE.
  - WRITE loops until the count is exhausted, then goes to SEND_STAT.
  - RD_ADDR goes to RD_WAIT, then to SEND.
  - SEND, after its handshake, goes to RD_ADDR if bytes remain, otherwise IDLE.
  - SEND_STAT goes to IDLE after its handshake.
- Address and count:
  - The address register increments by 1 after each write or read and wraps 8'hFF→8'h00.
  - A 9-bit remaining counter is loaded with `cnt`, or 256 when `cnt` = 0. W and R load it with 1.
- The full range 8'h00–8'hFF is reachable. The program port has no IO decode.
- `rx_ready` is high only in IDLE, GET_ADDR, GET_CNT and GET_DATA. Bytes are never dropped or consumed in any other state.
- `tx_valid`/`tx_data` stay stable from assertion until `tx_ready` is sampled high. `tx_valid` may assert with `tx_ready` already high, in which case the transfer completes in that cycle.
- A stalled `tx_ready` stalls the controller indefinitely. No timeout.

## Timing
- Reset values (async on `reset_n` low): state IDLE; `rx_ready`=0 during reset, 1 from the first clock after release; `tx_valid`=0; `tx_data`=0; `prg_we`=0; `prg_MA`=0; `prg_WD`=0; `busy`=0.
- Reset asserted mid-operation aborts immediately:
  - No further `prg_we` pulse is issued.
  - A pending tx byte is discarded.
  - Partially collected operands are lost.
- `prg_MA`, `prg_WD` and `prg_we` are registered outputs.
- Write: `prg_we`=1 for exactly one cycle per byte. `prg_MA`/`prg_WD` are valid in that same cycle.
- Write latency: the WRITE cycle is the cycle after the last operand byte is accepted.
- Fill issues `cnt` back-to-back write cycles.
- Read: `prg_MA` is driven in RD_ADDR. The RAM samples it at the end of that cycle. `prg_RD` is captured at the end of RD_WAIT. `tx_valid` rises in SEND, 3 cycles after the addr byte is accepted.
- Dump byte rate: with `tx_ready` tied high, one byte every 3 cycles.
- `busy` is high from the cycle after the command byte is accepted until the cycle after the final tx handshake.

## Test plan
- Write then read:
  - Send 'W',8'h10,8'hA5. Expect one `prg_we` pulse with MA=8'h10, WD=8'hA5, then tx 8'h06.
  - Send 'R',8'h10. Expect tx 8'hA5.
- Dump with wrap: preload 8'hFE=8'h11, 8'hFF=8'h22, 8'h00=8'h33. Send 'D',8'hFE,8'h03. Expect tx 8'h11, 8'h22, 8'h33, in order, then `busy` low.
- Fill of 256: send 'F',8'h00,8'h00,8'h5A. Expect exactly 256 consecutive `prg_we` cycles, MA 8'h00…8'hFF, then `ACK`. A subsequent 'R',8'h80 returns 8'h5A.
- Unknown command and backpressure: send 8'h41. Expect tx 8'h15 with no `prg_we`. Hold `tx_ready` low for 10 cycles: `tx_valid`/`tx_data` stay stable and `rx_ready` stays 0.
- Reset mid-fill: assert `reset_n` low during the 5th write of 'F',8'h20,8'h10,8'hFF. Expect all outputs at reset values immediately and no `ACK`. The next 'R',8'h24 returns the pre-fill value, and 'R',8'h23 returns 8'hFF.
